// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-128 encryption controller.
package ascon_pkg;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;

  typedef logic [3:0] round_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    WAIT_AD = 3'd2,
    AD      = 3'd3,
    WAIT_PT = 3'd4,
    PT      = 3'd5,
    FINAL   = 3'd6,
    DONE    = 3'd7
  } state_t;

endpackage

// File: rtl/ascon_ctrl_fsm_if.sv
// Block-source handshake between the ASCON controller and whoever feeds it.
interface ascon_ctrl_fsm_if;

  logic start_i;
  logic data_valid_i;
  logic last_block_i;
  logic data_ready_o;
  logic done_o;
  logic busy_o;

  modport master (
    output start_i, data_valid_i, last_block_i,
    input  data_ready_o, done_o, busy_o
  );

  modport slave (
    input  start_i, data_valid_i, last_block_i,
    output data_ready_o, done_o, busy_o
  );

endinterface

// File: rtl/round_counter.sv
// Round index counter: synchronous load has priority over increment.
module round_counter #(
  parameter int CNT_W = 4,
  parameter int LAST  = 11
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] load_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count_q <= '0;
    end else if (ld_i) begin
      count_q <= load_i;
    end else if (en_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == CNT_W'(LAST));

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Moore controller sequencing ASCON-128 encryption: p12 init, one AD block,
// N plaintext blocks (p6 each), p12 finalization.
module ascon_ctrl_fsm
  import ascon_pkg::*;
#(
  parameter int ROUNDS_A = ascon_pkg::ROUNDS_A,
  parameter int ROUNDS_B = ascon_pkg::ROUNDS_B,
  parameter int CNT_W    = 4
) (
  input  logic                clock_i,
  input  logic                resetb_i,
  ascon_ctrl_fsm_if.slave     bus,
  output logic [CNT_W-1:0]    round_o,
  output logic                en_state_o,
  output logic                sel_init_o,
  output logic                en_xor_data_begin_o,
  output logic                en_xor_key_begin_o,
  output logic                en_xor_key_end_o,
  output logic                en_xor_lsb_end_o,
  output logic                en_cipher_o,
  output logic                en_tag_o,
  output logic                cipher_valid_o
);

  // p6 phases start mid-schedule so both p12 and p6 terminate on the same count.
  localparam logic [CNT_W-1:0] CNT_P6_START = CNT_W'(ROUNDS_A - ROUNDS_B);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last, cnt_inc, cnt_ld;
  logic [CNT_W-1:0] cnt_ld_val;
  logic             data_ready, done;

  round_counter #(.CNT_W(CNT_W), .LAST(ROUNDS_A - 1)) u_round_counter (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .en_i     (cnt_inc),
    .ld_i     (cnt_ld),
    .load_i   (cnt_ld_val),
    .count_o  (cnt),
    .last_o   (cnt_last)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= IDLE;
      cipher_valid_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      cipher_valid_o <= en_cipher_o;
    end
  end

  // NOTE: every signal written below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d             = state_q;
    cnt_inc             = 1'b0;
    cnt_ld              = 1'b0;
    cnt_ld_val          = '0;
    data_ready          = 1'b0;
    done                = 1'b0;
    en_state_o          = 1'b0;
    sel_init_o          = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_end_o    = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_ld = 1'b1;
        if (bus.start_i) state_d = INIT;
      end
      INIT: begin
        en_state_o       = 1'b1;
        cnt_inc          = 1'b1;
        sel_init_o       = (cnt == '0);
        en_xor_key_end_o = cnt_last;
        if (cnt_last) begin
          cnt_ld  = 1'b1;
          state_d = WAIT_AD;
        end
      end
      WAIT_AD: begin
        data_ready = 1'b1;
        if (bus.data_valid_i) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = CNT_P6_START;
          state_d    = AD;
        end
      end
      AD: begin
        en_state_o          = 1'b1;
        cnt_inc             = 1'b1;
        en_xor_data_begin_o = (cnt == CNT_P6_START);
        en_xor_lsb_end_o    = cnt_last;
        if (cnt_last) begin
          cnt_ld  = 1'b1;
          state_d = WAIT_PT;
        end
      end
      WAIT_PT: begin
        data_ready = 1'b1;
        if (bus.data_valid_i) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = bus.last_block_i ? '0 : CNT_P6_START;
          state_d    = bus.last_block_i ? FINAL : PT;
        end
      end
      PT: begin
        en_state_o          = 1'b1;
        cnt_inc             = 1'b1;
        en_xor_data_begin_o = (cnt == CNT_P6_START);
        en_cipher_o         = (cnt == CNT_P6_START);
        if (cnt_last) begin
          cnt_ld  = 1'b1;
          state_d = WAIT_PT;
        end
      end
      FINAL: begin
        en_state_o          = 1'b1;
        cnt_inc             = 1'b1;
        en_xor_data_begin_o = (cnt == '0);
        en_xor_key_begin_o  = (cnt == '0);
        en_cipher_o         = (cnt == '0);
        en_xor_key_end_o    = cnt_last;
        en_tag_o            = cnt_last;
        if (cnt_last) begin
          cnt_ld  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        cnt_ld  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign round_o          = cnt;
  assign bus.data_ready_o = data_ready;
  assign bus.done_o       = done;
  assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Scoreboard bench for ascon_ctrl_fsm: stimulus queues the expected output
// vector for each cycle, a negedge monitor pops and compares.
module tb_ascon_ctrl_fsm;

  typedef struct packed {
    logic       ready;
    logic [3:0] rnd;
    logic       en_state;
    logic       sel_init;
    logic       xdb;
    logic       xkb;
    logic       xke;
    logic       xle;
    logic       cipher;
    logic       tag;
    logic       cvalid;
    logic       done;
    logic       busy;
  } out_t;

  typedef struct {
    string tag;
    out_t  v;
  } exp_t;

  typedef enum int {P_IDLE, P_INIT, P_WAIT, P_AD, P_PT, P_FIN, P_DONE} ph_e;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] round;
  logic       en_state, sel_init, xdb, xkb, xke, xle, en_cipher, en_tag, cvalid;

  ascon_ctrl_fsm_if bus();

  ascon_ctrl_fsm dut (
    .clock_i             (clk),
    .resetb_i            (resetb),
    .bus                 (bus.slave),
    .round_o             (round),
    .en_state_o          (en_state),
    .sel_init_o          (sel_init),
    .en_xor_data_begin_o (xdb),
    .en_xor_key_begin_o  (xkb),
    .en_xor_key_end_o    (xke),
    .en_xor_lsb_end_o    (xle),
    .en_cipher_o         (en_cipher),
    .en_tag_o            (en_tag),
    .cipher_valid_o      (cvalid)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic prev_cipher = 1'b0;

  task automatic check(input string tag, input out_t act, input out_t exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b required %b (rdy,rnd4,en_st,sel,xdb,xkb,xke,xle,ciph,tag,cv,done,busy)",
               tag, $time, act, exp_v);
    end
  endtask

  // Monitor: one expected vector per cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t x;
        out_t a;
        x = sb_q.pop_front();
        a = '{bus.data_ready_o, round, en_state, sel_init, xdb, xkb, xke, xle,
              en_cipher, en_tag, cvalid, bus.done_o, bus.busy_o};
        check(x.tag, a, x.v);
      end
    end
  end

  function automatic out_t mk(input ph_e ph, input int r);
    out_t e;
    e = '0;
    case (ph)
      P_INIT: begin
        e.rnd = 4'(r); e.en_state = 1'b1; e.busy = 1'b1;
        e.sel_init = (r == 0); e.xke = (r == 11);
      end
      P_WAIT: begin
        e.ready = 1'b1; e.busy = 1'b1;
      end
      P_AD: begin
        e.rnd = 4'(r); e.en_state = 1'b1; e.busy = 1'b1;
        e.xdb = (r == 6); e.xle = (r == 11);
      end
      P_PT: begin
        e.rnd = 4'(r); e.en_state = 1'b1; e.busy = 1'b1;
        e.xdb = (r == 6); e.cipher = (r == 6);
      end
      P_FIN: begin
        e.rnd = 4'(r); e.en_state = 1'b1; e.busy = 1'b1;
        e.xdb = (r == 0); e.xkb = (r == 0); e.cipher = (r == 0);
        e.xke = (r == 11); e.tag = (r == 11);
      end
      P_DONE: begin
        e.done = 1'b1; e.busy = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic step(input out_t e_in, input string tag);
    exp_t x;
    out_t e;
    e = e_in;
    e.cvalid = prev_cipher;
    prev_cipher = e.cipher;
    x.tag = tag;
    x.v = e;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // One full encryption; abort_at >= 0 drops reset during FINAL at that round.
  task automatic run_enc(input int n_pt, input int stall, input bit poke, input int abort_at);
    bus.start_i = 1'b1;
    step(mk(P_IDLE, 0), "idle_start");
    bus.start_i = 1'b0;
    for (int r = 0; r < 12; r++) begin
      bus.data_valid_i = poke && (r == 3);
      step(mk(P_INIT, r), "init");
    end
    bus.data_valid_i = 1'b1;
    step(mk(P_WAIT, 0), "wait_ad");
    bus.data_valid_i = 1'b0;
    for (int r = 6; r < 12; r++) begin
      bus.start_i = poke && (r == 8);
      step(mk(P_AD, r), "ad");
    end
    bus.start_i = 1'b0;
    for (int i = 0; i < n_pt; i++) begin
      for (int s = 0; s < ((i == 0) ? stall : 0); s++) step(mk(P_WAIT, 0), "pt_stall");
      bus.data_valid_i = 1'b1;
      bus.last_block_i = 1'b0;
      step(mk(P_WAIT, 0), "wait_pt");
      bus.data_valid_i = 1'b0;
      for (int r = 6; r < 12; r++) step(mk(P_PT, r), "pt");
    end
    bus.data_valid_i = 1'b1;
    bus.last_block_i = 1'b1;
    step(mk(P_WAIT, 0), "wait_last");
    bus.data_valid_i = 1'b0;
    bus.last_block_i = 1'b0;
    for (int r = 0; r < 12; r++) begin
      if (r == abort_at) begin
        resetb = 1'b0;
        prev_cipher = 1'b0;
        step('0, "abort");
        step('0, "abort_hold");
        resetb = 1'b1;
        step('0, "abort_release");
        return;
      end
      step(mk(P_FIN, r), "final");
    end
    step(mk(P_DONE, 0), "done");
    step(mk(P_IDLE, 0), "back_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i      = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.last_block_i = 1'b0;
    @(posedge clk);
    #1;

    // Reset held low: inputs toggle, outputs stay quiet.
    for (int i = 0; i < 4; i++) begin
      bus.start_i      = i[0];
      bus.data_valid_i = ~i[0];
      step('0, "reset_hold");
    end
    bus.start_i      = 1'b0;
    bus.data_valid_i = 1'b0;
    resetb = 1'b1;
    step(mk(P_IDLE, 0), "idle");
    bus.data_valid_i = 1'b1;
    step(mk(P_IDLE, 0), "idle_valid_ignored");
    bus.data_valid_i = 1'b0;

    run_enc(1, 0, 1'b0, -1);   // nominal
    run_enc(2, 5, 1'b0, -1);   // stall in WAIT_PT, two blocks
    run_enc(1, 0, 1'b1, -1);   // stray start/valid pulses
    run_enc(1, 0, 1'b0, 5);    // async abort mid-FINAL
    step(mk(P_IDLE, 0), "post_abort_idle");
    run_enc(1, 0, 1'b0, -1);   // rerun after abort
    run_enc(0, 0, 1'b0, -1);   // single (last) block

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
- Moore controller that sequences the ASCON-128 encryption datapath: the 320-bit state registers built from 64-bit enable DFFs, the permutation round, the key/data/domain XORs, and the cipher/tag capture registers.
- Runs initialization (p12), one associated-data block (p6), N plaintext blocks (p6 each), then finalization (p12).
- Drives the register enables, XOR enables and round index, and handshakes with the block source.

Parameters:
- ROUNDS_A, 12, rounds of p^a (init, finalization).
- ROUNDS_B, 6, rounds of p^b (AD, plaintext).
- CNT_W, 4, round counter width.

Ports:
- clock_i  in  1  system clock.
- resetb_i  in  1  reset. One clock; reset is asynchronous and active-low.
- start_i  in  1  start a new encryption; sampled in IDLE only.
- data_valid_i  in  1  an AD or plaintext block is present on the datapath input.
- last_block_i  in  1  the current plaintext block is the final one; qualified by data_valid_i in WAIT_PT.
- data_ready_o  out  1  controller accepts a block (WAIT_AD or WAIT_PT).
- round_o  out  CNT_W  round index fed to constant addition.
- en_state_o  out  1  state registers load the permutation output.
- sel_init_o  out  1  permutation input = IV||K||N instead of the state.
- en_xor_data_begin_o  out  1  XOR data block into x0 before the round.
- en_xor_key_begin_o  out  1  XOR 0||K into x1..x4 before the round.
- en_xor_key_end_o  out  1  XOR key into the state after the round.
- en_xor_lsb_end_o  out  1  XOR the domain-separation bit into x4 LSB after the round.
- en_cipher_o  out  1  capture x0^data into the 64-bit cipher register.
- en_tag_o  out  1  capture the tag register.
- cipher_valid_o  out  1  registered; pulses one cycle after en_cipher_o.
- done_o  out  1  encryption complete (DONE state).
- busy_o  out  1  state != IDLE.

Behaviour:
- States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE. One-hot or binary encoding is allowed.
- Reset (async, resetb_i=0): state=IDLE, counter=0, cipher_valid_o=0. Every output is 0 while reset is low and in IDLE. Reset mid-operation aborts immediately, with no partial completion.
- IDLE:
  - start_i=1 → INIT, counter=0.
  - Other inputs are ignored.
- INIT: one round per cycle, en_state_o=1.
  - Counter 0: sel_init_o=1.
  - Counter ROUNDS_A-1 (11): en_xor_key_end_o=1, then → WAIT_AD, counter=0.
- WAIT_AD:
  - data_ready_o=1.
  - data_valid_i=1 → AD, counter=12-ROUNDS_B (6).
  - Otherwise hold, with no enables asserted.
- AD: en_state_o=1.
  - First cycle: en_xor_data_begin_o=1.
  - Counter 11: en_xor_lsb_end_o=1, then → WAIT_PT, counter=0.
- WAIT_PT:
  - data_ready_o=1.
  - data_valid_i & !last_block_i → PT, counter=6.
  - data_valid_i & last_block_i → FINAL, counter=0.
- PT: en_state_o=1.
  - First cycle: en_xor_data_begin_o=1 and en_cipher_o=1.
  - Counter 11 → WAIT_PT.
- FINAL: en_state_o=1.
  - First cycle (counter 0): en_xor_data_begin_o, en_xor_key_begin_o and en_cipher_o all =1.
  - Counter 11: en_xor_key_end_o=1 and en_tag_o=1, then → DONE.
- DONE: done_o=1 for exactly one cycle, then → IDLE.
- Counter behaviour:
  - Increments by 1 in round states.
  - Is 0 in IDLE, WAIT_* and DONE.
  - round_o = counter.
  - Never exceeds 11; the terminal compare is on 11 for both p12 and p6.
- Handshake:
  - A block is accepted on the cycle data_ready_o & data_valid_i.
  - The source holds the block stable through the first round cycle that follows.
  - data_valid_i is ignored outside WAIT_*.
  - start_i is ignored when not in IDLE.
- Latency from start_i to the first data_ready_o: 13 cycles.
- Latency from last-block acceptance to done_o: 13 cycles.

Decomposition:
- Shared package ascon_pkg holds:
  - state_t enum.
  - ROUNDS_A and ROUNDS_B constants.
  - round_t typedef (logic[3:0]).
- Sub-module round_counter:
  - async reset, enable, synchronous load of value load_i, increment.
  - Outputs count_o and last_o (count==11).
- The FSM instantiates round_counter; output decode is purely combinational from state and counter.

Test Plan:
1. Reset: hold resetb_i=0, toggle start_i and data_valid_i → all outputs 0, busy_o=0.
2. Nominal run, start at cycle 0, blocks offered immediately → INIT cycles 1-12, data_ready_o at 13 (AD accepted), AD cycles 14-19 with en_xor_lsb_end_o at 19, WAIT_PT 20, PT 21-26 (en_cipher_o 21, cipher_valid_o 22), WAIT_PT 27 (last block accepted), FINAL 28-39 (en_xor_key_begin_o 28, en_tag_o 39), done_o at 40, IDLE at 41.
3. Stall: withhold data_valid_i for 5 cycles in WAIT_PT → data_ready_o stays 1, en_state_o=0, round_o=0, no cipher pulse; on valid, PT starts with round_o=6.
4. Ignored inputs: start_i pulsed during AD and data_valid_i pulsed during INIT → no state change; the timing of scenario 2 is unchanged.
5. Async abort: drop resetb_i mid-FINAL at round_o=5 → outputs 0 within the same cycle with no clock edge needed; after release, start_i reruns scenario 2 correctly.
6. Single block: last_block_i=1 on the first WAIT_PT → FINAL starts directly with en_xor_data_begin_o, en_xor_key_begin_o and en_cipher_o all at 1; done_o arrives 13 cycles later.
